// File: rtl/drive_cmd_scheduler.sv
// drive_cmd_scheduler
//   Chooses between the Bluetooth speed command and the two local
//   pushbuttons. The manual buttons win over Bluetooth. The block ramps the
//   motor speed one level per ramp period. Before any reversal it brakes
//   through zero. A watchdog stops the motors when a non-zero Bluetooth
//   command stays unchanged for too long.
//
//   Ports
//     FPGA_CLK1_50 : 50 MHz system clock
//     reset_n      : asynchronous active-low reset
//     bt_cmd[3:0]  : raw BT command, [3] = dir (1 = fwd), [2:0] = speed (0 = stop)
//     key_n[1:0]   : raw pushbuttons, active-low, [0] = manual fwd, [1] = manual back
//     smk_key[1:0] : SMK_control KEY, active-low, [0] low = fwd, [1] low = back
//     smk_sw[3:0]  : SMK_control SW = {1'b0, active_speed}
//     src_manual   : manual source owns the drive
//     wdt_fault    : watchdog fault latched
//     ramping      : active speed/direction not yet at target

// Debounce for one synchronised key. The level follows din once din has
// differed from the level for CYCLES consecutive cycles.
module drive_cmd_key_db #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         lvl_q, lvl_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (din == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = din;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign dout = lvl_q;
endmodule

module drive_cmd_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RAMP_CYCLES     = 2500000,
  parameter int WDT_CYCLES      = 250000000,
  parameter int MANUAL_SPEED    = 3
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic [3:0] bt_cmd,
  input  logic [1:0] key_n,
  output logic [1:0] smk_key,
  output logic [3:0] smk_sw,
  output logic       src_manual,
  output logic       wdt_fault,
  output logic       ramping
);
  localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_CYCLES - 1);
  localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYCLES - 1);
  localparam logic [2:0]    MAN_SPD  = 3'(MANUAL_SPEED);

  typedef enum logic [1:0] {SRC_IDLE, SRC_BT, SRC_FAULT, SRC_MANUAL} src_e;

  // input synchronisers (bt_prev_q is one cycle behind bt_s2_q for change detect)
  logic [3:0] bt_s1_q, bt_s2_q, bt_prev_q;
  logic [1:0] key_s1_q, key_s2_q;
  logic [1:0] key_db;

  // target selection
  src_e       src_q, src_d;
  logic [2:0] tgt_spd_q, tgt_spd_d;
  logic       tgt_dir_q, tgt_dir_d;

  // watchdog
  logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic          wdt_fault_q, wdt_fault_d;

  // ramp
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [2:0]    act_spd_q, act_spd_d;
  logic          act_dir_q, act_dir_d;
  logic          dir_pend;
  logic [2:0]    eff_spd;

  // output registers
  logic [1:0] smk_key_q, smk_key_d;
  logic [3:0] smk_sw_q, smk_sw_d;
  logic       src_manual_q, src_manual_d;
  logic       ramping_q, ramping_d;

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      bt_s1_q   <= '0;
      bt_s2_q   <= '0;
      bt_prev_q <= '0;
      key_s1_q  <= 2'b11;
      key_s2_q  <= 2'b11;
    end else begin
      bt_s1_q   <= bt_cmd;
      bt_s2_q   <= bt_s1_q;
      bt_prev_q <= bt_s2_q;
      key_s1_q  <= key_n;
      key_s2_q  <= key_s1_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_key
    drive_cmd_key_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (FPGA_CLK1_50),
      .rst_n(reset_n),
      .din  (key_s2_q[g]),
      .dout (key_db[g])
    );
  end

  // Source priority: one key > both keys (stop) > fault > BT > idle.
  // Direction holds whenever the winning source does not name one.
  always_comb begin
    src_d     = SRC_IDLE;
    tgt_spd_d = 3'd0;
    tgt_dir_d = tgt_dir_q;
    if (key_db == 2'b10) begin
      src_d     = SRC_MANUAL;
      tgt_spd_d = MAN_SPD;
      tgt_dir_d = 1'b1;
    end else if (key_db == 2'b01) begin
      src_d     = SRC_MANUAL;
      tgt_spd_d = MAN_SPD;
      tgt_dir_d = 1'b0;
    end else if (key_db == 2'b00) begin
      src_d     = SRC_MANUAL;
    end else if (wdt_fault_q) begin
      src_d     = SRC_FAULT;
    end else if (bt_s2_q[2:0] != 3'd0) begin
      src_d     = SRC_BT;
      tgt_spd_d = bt_s2_q[2:0];
      tgt_dir_d = bt_s2_q[3];
    end
  end

  // The counter advances only while BT drives a non-zero speed with an
  // unchanged command. It saturates and holds otherwise. Only a command
  // change rewinds it.
  always_comb begin
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fault_d = wdt_fault_q;
    if (bt_s2_q != bt_prev_q) begin
      wdt_cnt_d = '0;
    end else if (src_q == SRC_BT && bt_s2_q[2:0] != 3'd0 && wdt_cnt_q != WDT_MAX) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
    end
    if (bt_s2_q[2:0] == 3'd0) begin
      wdt_fault_d = 1'b0;
    end else if (wdt_cnt_q == WDT_MAX) begin
      wdt_fault_d = 1'b1;
    end
  end

  // A pending reversal forces the effective target to zero. The direction
  // flips only while stopped, and that flip cycle counts as "matched". The
  // ramp toward the new target therefore begins on the following cycle.
  assign dir_pend = (tgt_dir_q != act_dir_q);
  assign eff_spd  = dir_pend ? 3'd0 : tgt_spd_q;

  always_comb begin
    act_spd_d  = act_spd_q;
    act_dir_d  = act_dir_q;
    ramp_cnt_d = ramp_cnt_q;
    if (act_spd_q == eff_spd) begin
      ramp_cnt_d = '0;
      if (dir_pend) act_dir_d = tgt_dir_q;
    end else if (ramp_cnt_q == RAMP_MAX) begin
      ramp_cnt_d = '0;
      if (act_spd_q < eff_spd && act_spd_q != 3'd7) begin
        act_spd_d = act_spd_q + 3'd1;
      end else if (act_spd_q > eff_spd && act_spd_q != 3'd0) begin
        act_spd_d = act_spd_q - 3'd1;
      end
    end else begin
      ramp_cnt_d = ramp_cnt_q + 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // active speed register rather than trailing it by a cycle.
  always_comb begin
    smk_key_d    = 2'b11;
    if (act_spd_d != 3'd0) smk_key_d = act_dir_d ? 2'b10 : 2'b01;
    smk_sw_d     = {1'b0, act_spd_d};
    src_manual_d = (src_d == SRC_MANUAL);
    ramping_d    = (act_spd_d != tgt_spd_d) || (act_dir_d != tgt_dir_d);
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      src_q        <= SRC_IDLE;
      tgt_spd_q    <= 3'd0;
      tgt_dir_q    <= 1'b1;
      wdt_cnt_q    <= '0;
      wdt_fault_q  <= 1'b0;
      ramp_cnt_q   <= '0;
      act_spd_q    <= 3'd0;
      act_dir_q    <= 1'b1;
      smk_key_q    <= 2'b11;
      smk_sw_q     <= 4'd0;
      src_manual_q <= 1'b0;
      ramping_q    <= 1'b0;
    end else begin
      src_q        <= src_d;
      tgt_spd_q    <= tgt_spd_d;
      tgt_dir_q    <= tgt_dir_d;
      wdt_cnt_q    <= wdt_cnt_d;
      wdt_fault_q  <= wdt_fault_d;
      ramp_cnt_q   <= ramp_cnt_d;
      act_spd_q    <= act_spd_d;
      act_dir_q    <= act_dir_d;
      smk_key_q    <= smk_key_d;
      smk_sw_q     <= smk_sw_d;
      src_manual_q <= src_manual_d;
      ramping_q    <= ramping_d;
    end
  end

  assign smk_key    = smk_key_q;
  assign smk_sw     = smk_sw_q;
  assign src_manual = src_manual_q;
  assign wdt_fault  = wdt_fault_q;
  assign ramping    = ramping_q;
endmodule
